// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, change-dispenser FSM encoding and
// the coin-select enum used between the picker and the sequencer.
package vend_pkg;

  localparam int unsigned DIME_C    = 10;
  localparam int unsigned QUARTER_C = 25;
  localparam int unsigned DOLLAR_C  = 100;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_EJECT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    DIME    = 2'd1,
    QUARTER = 2'd2,
    DOLLAR  = 2'd3
  } coin_e;

  function automatic int unsigned coin_value(input coin_e coin);
    case (coin)
      DOLLAR:  return DOLLAR_C;
      QUARTER: return QUARTER_C;
      DIME:    return DIME_C;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_ctrl_coin_select.sv
// Combinational coin picker: largest coin that keeps the remainder payable
// in dimes, never choosing a coin whose inventory is empty.
module coin_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 12,
  parameter int CNT_W = 8
) (
  input  logic [AMT_W-1:0] rem,
  input  logic [CNT_W-1:0] inv_dollar,
  input  logic [CNT_W-1:0] inv_quarter,
  input  logic [CNT_W-1:0] inv_dime,
  output coin_e            coin
);

  logic [3:0] rem_mod10;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    coin      = NONE;
    rem_mod10 = 4'(rem % AMT_W'(DIME_C));
    if (rem >= AMT_W'(DOLLAR_C) && inv_dollar != '0) begin
      coin = DOLLAR;
    end else if (rem >= AMT_W'(QUARTER_C) && inv_quarter != '0 &&
                 (rem_mod10 == 4'd5 || rem >= AMT_W'(2 * QUARTER_C))) begin
      // A quarter is only safe when the leftover can still be made of dimes.
      coin = QUARTER;
    end else if (rem >= AMT_W'(DIME_C) && inv_dime != '0) begin
      coin = DIME;
    end
  end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser sequencer: accepts a change amount, ejects coins one at a
// time with an ack handshake, tracks inventory and reports any shortfall.
module change_dispenser_ctrl
  import vend_pkg::*;
#(
  parameter int AMT_W        = 12,
  parameter int CNT_W        = 8,
  parameter int DOLLAR_INIT  = 8,
  parameter int QUARTER_INIT = 16,
  parameter int DIME_INIT    = 20,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  input  logic             refill,
  output logic             eject_dollar,
  output logic             eject_quarter,
  output logic             eject_dime,
  input  logic             eject_ack,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remain,
  output logic [CNT_W-1:0] inv_dollar,
  output logic [CNT_W-1:0] inv_quarter,
  output logic [CNT_W-1:0] inv_dime
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  coin_e             coin_q, coin_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  inv_dollar_q, inv_dollar_d;
  logic [CNT_W-1:0]  inv_quarter_q, inv_quarter_d;
  logic [CNT_W-1:0]  inv_dime_q, inv_dime_d;
  logic              short_q, short_d;
  logic [AMT_W-1:0]  remain_q, remain_d;

  coin_e             pick;
  logic [AMT_W-1:0]  coin_amt;

  coin_select #(
    .AMT_W (AMT_W),
    .CNT_W (CNT_W)
  ) u_coin_select (
    .rem         (rem_q),
    .inv_dollar  (inv_dollar_q),
    .inv_quarter (inv_quarter_q),
    .inv_dime    (inv_dime_q),
    .coin        (pick)
  );

  assign coin_amt = AMT_W'(coin_value(coin_q));

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    coin_d        = coin_q;
    wait_d        = wait_q;
    inv_dollar_d  = inv_dollar_q;
    inv_quarter_d = inv_quarter_q;
    inv_dime_d    = inv_dime_q;
    short_d       = short_q;
    remain_d      = remain_q;

    case (state_q)
      ST_IDLE: begin
        // Refill lands in the same edge as an accept, so the request sees full bins.
        if (refill) begin
          inv_dollar_d  = CNT_W'(DOLLAR_INIT);
          inv_quarter_d = CNT_W'(QUARTER_INIT);
          inv_dime_d    = CNT_W'(DIME_INIT);
        end
        if (chg_valid) begin
          rem_d    = chg_amt;
          short_d  = 1'b0;
          remain_d = '0;
          state_d  = ST_SELECT;
        end
      end

      ST_SELECT: begin
        wait_d = '0;
        if (pick != NONE) begin
          coin_d  = pick;
          state_d = ST_EJECT;
        end else begin
          remain_d = rem_q;
          short_d  = (rem_q != '0);
          state_d  = ST_DONE;
        end
      end

      ST_EJECT: begin
        if (eject_ack) begin
          rem_d   = rem_q - coin_amt;
          state_d = ST_SELECT;
          case (coin_q)
            DOLLAR:  inv_dollar_d  = inv_dollar_q  - CNT_W'(1);
            QUARTER: inv_quarter_d = inv_quarter_q - CNT_W'(1);
            DIME:    inv_dime_d    = inv_dime_q    - CNT_W'(1);
            default: ;
          endcase
        end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
          // Hopper jammed: abandon the coin without charging inventory.
          remain_d = rem_q;
          short_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      coin_q        <= NONE;
      wait_q        <= '0;
      inv_dollar_q  <= CNT_W'(DOLLAR_INIT);
      inv_quarter_q <= CNT_W'(QUARTER_INIT);
      inv_dime_q    <= CNT_W'(DIME_INIT);
      short_q       <= 1'b0;
      remain_q      <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      coin_q        <= coin_d;
      wait_q        <= wait_d;
      inv_dollar_q  <= inv_dollar_d;
      inv_quarter_q <= inv_quarter_d;
      inv_dime_q    <= inv_dime_d;
      short_q       <= short_d;
      remain_q      <= remain_d;
    end
  end

  assign chg_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign eject_dollar  = (state_q == ST_EJECT) && (coin_q == DOLLAR);
  assign eject_quarter = (state_q == ST_EJECT) && (coin_q == QUARTER);
  assign eject_dime    = (state_q == ST_EJECT) && (coin_q == DIME);
  assign short         = short_q;
  assign remain        = remain_q;
  assign inv_dollar    = inv_dollar_q;
  assign inv_quarter   = inv_quarter_q;
  assign inv_dime      = inv_dime_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench for change_dispenser_ctrl: directed scenarios plus
// randomized requests checked against a greedy change-making model.
module tb_change_dispenser_ctrl;

  localparam int AMT_W        = 12;
  localparam int CNT_W        = 8;
  localparam int DOLLAR_INIT  = 8;
  localparam int QUARTER_INIT = 16;
  localparam int DIME_INIT    = 20;
  localparam int ACK_TIMEOUT  = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             chg_valid = 1'b0;
  logic [AMT_W-1:0] chg_amt = '0;
  logic             chg_ready;
  logic             refill = 1'b0;
  logic             eject_dollar, eject_quarter, eject_dime;
  logic             eject_ack = 1'b0;
  logic             busy, done, short;
  logic [AMT_W-1:0] remain;
  logic [CNT_W-1:0] inv_dollar, inv_quarter, inv_dime;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: coin bins and the expected outcome of one request.
  int m_dol, m_qtr, m_dim;
  int exp_q[$];
  int obs_q[$];
  int exp_rem;

  change_dispenser_ctrl #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .DOLLAR_INIT(DOLLAR_INIT),
    .QUARTER_INIT(QUARTER_INIT), .DIME_INIT(DIME_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chg_valid(chg_valid), .chg_amt(chg_amt),
    .chg_ready(chg_ready), .refill(refill), .eject_dollar(eject_dollar),
    .eject_quarter(eject_quarter), .eject_dime(eject_dime), .eject_ack(eject_ack),
    .busy(busy), .done(done), .short(short), .remain(remain),
    .inv_dollar(inv_dollar), .inv_quarter(inv_quarter), .inv_dime(inv_dime)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic model_reload();
    m_dol = DOLLAR_INIT;
    m_qtr = QUARTER_INIT;
    m_dim = DIME_INIT;
  endtask

  // Greedy change making: prefer big coins, but only take a quarter when the
  // leftover is still reachable with dimes.
  task automatic model_run(input int amt);
    int r;
    r = amt;
    exp_q = {};
    forever begin
      if (r >= 100 && m_dol > 0) begin
        r -= 100; m_dol--; exp_q.push_back(100);
      end else if (r >= 25 && m_qtr > 0 && (r % 10 == 5 || r >= 50)) begin
        r -= 25; m_qtr--; exp_q.push_back(25);
      end else if (r >= 10 && m_dim > 0) begin
        r -= 10; m_dim--; exp_q.push_back(10);
      end else begin
        break;
      end
    end
    exp_rem = r;
  endtask

  task automatic do_reset();
    chg_valid = 1'b0;
    refill    = 1'b0;
    eject_ack = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reload();
  endtask

  // Drive one request and act as the hopper until done; compare everything.
  task automatic serve_request(input int amt, input int dly_lo, input int dly_hi,
                               input int refill_at, input bit refill_now,
                               input bit keep_valid, input int next_amt,
                               input bit spurious);
    int   w, hold, dly, nstrobe;
    bit   ack_on, got_done, bad_ready, bad_gap, bad_hot, coins_bad;
    logic got_short;
    logic [AMT_W-1:0] got_remain;

    if (refill_now) model_reload();
    model_run(amt);
    chg_valid = 1'b1;
    chg_amt   = AMT_W'(amt);
    refill    = refill_now;
    w = 0;
    while (chg_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    refill    = 1'b0;
    chg_valid = keep_valid;
    if (keep_valid) chg_amt = AMT_W'(next_amt);
    n_vec++;
    if (w >= 1000 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL accept amt=%0d: busy=%b after %0d waits, want busy=1", amt, busy, w);
    end

    hold = 0; ack_on = 0; got_done = 0; bad_ready = 0; bad_gap = 0; bad_hot = 0;
    got_short = 1'bx; got_remain = 'x;
    obs_q = {};
    dly = $urandom_range(dly_hi, dly_lo);
    for (int cyc = 0; cyc < 5000 && !got_done; cyc++) begin
      nstrobe = int'(eject_dollar) + int'(eject_quarter) + int'(eject_dime);
      refill  = (cyc == refill_at);
      if (done === 1'b1) begin
        got_done   = 1;
        got_short  = short;
        got_remain = remain;
        eject_ack  = 1'b0;
        refill     = 1'b0;
      end else begin
        if (chg_ready !== 1'b0 || busy !== 1'b1) bad_ready = 1;
        if (nstrobe > 1) bad_hot = 1;
        if (ack_on) begin
          ack_on = 0;
          eject_ack = 1'b0;
          if (nstrobe != 0) bad_gap = 1;
        end else if (nstrobe == 1) begin
          if (hold >= dly) begin
            eject_ack = 1'b1;
            ack_on = 1;
            hold = 0;
            dly = $urandom_range(dly_hi, dly_lo);
            obs_q.push_back(eject_dollar ? 100 : (eject_quarter ? 25 : 10));
          end else begin
            eject_ack = 1'b0;
            hold++;
          end
        end else begin
          eject_ack = spurious && ($urandom_range(3, 0) == 0);
        end
        @(negedge clk);
      end
    end

    n_vec++;
    if (!got_done) begin
      n_err++;
      $display("FAIL done_timeout amt=%0d: no done pulse within bound, want done=1", amt);
    end
    n_vec++;
    if (bad_ready || bad_hot || bad_gap) begin
      n_err++;
      $display("FAIL protocol amt=%0d: ready/busy_bad=%0b multi_strobe=%0b no_gap=%0b, want 0/0/0",
               amt, bad_ready, bad_hot, bad_gap);
    end
    coins_bad = (obs_q.size() != exp_q.size());
    if (!coins_bad)
      foreach (exp_q[i]) if (obs_q[i] != exp_q[i]) coins_bad = 1;
    n_vec++;
    if (coins_bad) begin
      n_err++;
      $display("FAIL coin_seq amt=%0d: got %0d coins %p, want %0d coins %p",
               amt, obs_q.size(), obs_q, exp_q.size(), exp_q);
    end
    n_vec++;
    if (got_short !== (exp_rem != 0) || got_remain !== AMT_W'(exp_rem)) begin
      n_err++;
      $display("FAIL result amt=%0d: short=%b remain=%0d, want short=%0b remain=%0d",
               amt, got_short, got_remain, exp_rem != 0, exp_rem);
    end
    n_vec++;
    if (inv_dollar !== CNT_W'(m_dol) || inv_quarter !== CNT_W'(m_qtr) || inv_dime !== CNT_W'(m_dim)) begin
      n_err++;
      $display("FAIL inventory amt=%0d: got %0d/%0d/%0d, want %0d/%0d/%0d", amt,
               inv_dollar, inv_quarter, inv_dime, m_dol, m_qtr, m_dim);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || chg_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL after_done amt=%0d: done=%b ready=%b busy=%b, want 0/1/0",
               amt, done, chg_ready, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (chg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || short !== 1'b0 || remain !== '0 ||
        {eject_dollar, eject_quarter, eject_dime} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b short=%b remain=%0d ej=%b%b%b, want 1/0/0/0/0/000",
               chg_ready, busy, done, short, remain, eject_dollar, eject_quarter, eject_dime);
    end
    n_vec++;
    if (inv_dollar !== 8'd8 || inv_quarter !== 8'd16 || inv_dime !== 8'd20) begin
      n_err++;
      $display("FAIL reset_inv: got %0d/%0d/%0d, want 8/16/20", inv_dollar, inv_quarter, inv_dime);
    end
  endtask

  task automatic test_mixed_160();
    do_reset();
    serve_request(160, 3, 3, -1, 0, 0, 0, 0);
    n_vec++;
    if (inv_dollar !== 8'd7 || inv_quarter !== 8'd14 || inv_dime !== 8'd19 || short !== 1'b0) begin
      n_err++;
      $display("FAIL mixed_160: inv %0d/%0d/%0d short=%b, want 7/14/19 short=0",
               inv_dollar, inv_quarter, inv_dime, short);
    end
  endtask

  task automatic test_dimes_only();
    serve_request(30, 1, 3, -1, 1, 0, 0, 0);
    n_vec++;
    if (inv_dime !== 8'd17 || inv_quarter !== 8'd16 || short !== 1'b0) begin
      n_err++;
      $display("FAIL dimes_30: inv_dime=%0d inv_quarter=%0d short=%b, want 17/16/0",
               inv_dime, inv_quarter, short);
    end
  endtask

  task automatic test_shortfall();
    do_reset();
    serve_request(800, 0, 1, -1, 0, 0, 0, 0);
    serve_request(400, 0, 1, -1, 0, 0, 0, 0);
    serve_request(190, 0, 1, -1, 0, 0, 0, 0);
    serve_request(45, 0, 2, -1, 0, 0, 0, 0);
    n_vec++;
    if (short !== 1'b1 || remain !== 12'd35 || inv_dime !== 8'd0 || inv_dollar !== 8'd0 || inv_quarter !== 8'd0) begin
      n_err++;
      $display("FAIL shortfall_45: short=%b remain=%0d inv %0d/%0d/%0d, want short=1 remain=35 inv 0/0/0",
               short, remain, inv_dollar, inv_quarter, inv_dime);
    end
  endtask

  task automatic test_zero_amt();
    chg_valid = 1'b1;
    chg_amt   = '0;
    @(negedge clk);
    chg_valid = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1 || {eject_dollar, eject_quarter, eject_dime} !== 3'b000) begin
      n_err++;
      $display("FAIL zero_select: done=%b busy=%b, want done=0 busy=1 no strobe", done, busy);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || short !== 1'b0 || remain !== '0 || {eject_dollar, eject_quarter, eject_dime} !== 3'b000) begin
      n_err++;
      $display("FAIL zero_done: done=%b short=%b remain=%0d, want 1/0/0", done, short, remain);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || chg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL zero_after: done=%b ready=%b, want 0/1", done, chg_ready);
    end
  endtask

  task automatic test_timeout();
    int w, high;
    do_reset();
    chg_valid = 1'b1;
    chg_amt   = 12'd100;
    @(negedge clk);
    chg_valid = 1'b0;
    w = 0;
    while (eject_dollar !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    high = 0;
    while (eject_dollar === 1'b1 && high < 400) begin
      @(negedge clk);
      high++;
    end
    n_vec++;
    if (high != ACK_TIMEOUT) begin
      n_err++;
      $display("FAIL timeout_len: eject_dollar high %0d cycles, want %0d", high, ACK_TIMEOUT);
    end
    n_vec++;
    if (done !== 1'b1 || short !== 1'b1 || remain !== 12'd100 || inv_dollar !== 8'd8) begin
      n_err++;
      $display("FAIL timeout_done: done=%b short=%b remain=%0d inv_dollar=%0d, want 1/1/100/8",
               done, short, remain, inv_dollar);
    end
    @(negedge clk);
    n_vec++;
    if (short !== 1'b1 || remain !== 12'd100 || chg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_hold: short=%b remain=%0d ready=%b, want 1/100/1", short, remain, chg_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    serve_request(30, 1, 2, 5, 0, 1, 45, 0);
    serve_request(45, 1, 2, 3, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_eject();
    int w;
    do_reset();
    serve_request(160, 0, 1, -1, 0, 0, 0, 0);
    chg_valid = 1'b1;
    chg_amt   = 12'd75;
    @(negedge clk);
    chg_valid = 1'b0;
    w = 0;
    while (eject_quarter !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (eject_quarter !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_setup: eject_quarter=%b, want 1", eject_quarter);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({eject_dollar, eject_quarter, eject_dime} !== 3'b000 || done !== 1'b0 || chg_ready !== 1'b1 ||
        inv_dollar !== 8'd8 || inv_quarter !== 8'd16 || inv_dime !== 8'd20) begin
      n_err++;
      $display("FAIL rst_mid: ej=%b%b%b done=%b ready=%b inv %0d/%0d/%0d, want 000/0/1 8/16/20",
               eject_dollar, eject_quarter, eject_dime, done, chg_ready, inv_dollar, inv_quarter, inv_dime);
    end
    rst_n = 1'b1;
    model_reload();
    w = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) w++;
    end
    n_vec++;
    if (w != 0) begin
      n_err++;
      $display("FAIL rst_no_done: %0d cycles with done/busy set, want 0", w);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      serve_request(int'($urandom_range(600, 0)), 0, 4, int'($urandom_range(30, 0)),
                    ($urandom_range(3, 0) == 0), 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_mixed_160();
    test_dimes_only();
    test_shortfall();
    test_zero_amt();
    test_timeout();
    test_back_to_back();
    test_reset_mid_eject();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
